// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath.
// Steps each instruction through fetch / decode / execute / memory /
// writeback as a Moore FSM. Fetch and data accesses share one memory port.
// The only input-dependent controls are PCWrite in FETCH (MemReady) and in
// BRANCH (Zero).
//
// Memory handshake: MemRead/MemWrite act as the request ("valid") and
// MemReady is the completion ("ready"). A transfer completes on a rising
// edge where the request is high and MemReady=1. While MemReady=0, the
// state, the request and every other control are held unchanged.
// MemReady is ignored in states that make no request.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             Halted,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;

  assign State      = state_q;
  assign InstrCount = count_q;

  // State register and retired-instruction counter; reset overrides all.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          // Stay in FETCH until memory delivers the instruction word.
          if (MemReady) begin
            state_q <= DECODE;
            count_q <= count_q + CNT_W'(1);
          end
        end
        DECODE: begin
          case (Opcode)
            OP_R:          state_q <= EXEC_R;
            OP_ADDI:       state_q <= EXEC_I;
            OP_LW, OP_SW:  state_q <= MEM_ADDR;
            OP_BEQ,
            OP_BNE:        state_q <= BRANCH;
            OP_JMP:        state_q <= JUMP;
            OP_HALT:       state_q <= HALT;
            default:       state_q <= FETCH;
          endcase
        end
        EXEC_R:   state_q <= WB_R;
        EXEC_I:   state_q <= WB_I;
        MEM_ADDR: begin
          // Only loads and stores reach here; anything else restarts fetch.
          if (Opcode == OP_LW)      state_q <= MEM_RD;
          else if (Opcode == OP_SW) state_q <= MEM_WR;
          else                      state_q <= FETCH;
        end
        MEM_RD: begin
          if (MemReady) state_q <= WB_MEM;
        end
        MEM_WR: begin
          if (MemReady) state_q <= FETCH;
        end
        WB_R:     state_q <= FETCH;
        WB_I:     state_q <= FETCH;
        WB_MEM:   state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        JUMP:     state_q <= FETCH;
        HALT:     state_q <= HALT;
        // Unused codes 13-15 recover to FETCH.
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Control decode from the registered state. Every control defaults to 0.
  always_comb begin
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_PLUS2;
    Halted   = 1'b0;
    case (state_q)
      FETCH: begin
        // Instruction read from PC. The PC advances only on the completing cycle.
        MemRead = 1'b1;
        IorD    = 1'b0;
        IRWrite = 1'b1;
        ALUSrc  = 1'b0;
        ALUOp   = ALU_ADD;
        PCWrite = MemReady;
        PCSrc   = PC_PLUS2;
      end
      DECODE: begin
        // The ALU precomputes the branch target while the opcode settles.
        ALUOp = ALU_ADD;
      end
      EXEC_R: begin
        ALUOp = ALU_FUNCT;
      end
      WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = ALU_FUNCT;
      end
      EXEC_I: begin
        ALUSrc = 1'b1;
        ALUOp  = ALU_ADD;
      end
      WB_I: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrc = 1'b1;
        ALUOp  = ALU_ADD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      BRANCH: begin
        // BEQ takes the branch on Zero; BNE (opcode bit 0 set) on ~Zero.
        ALUOp   = ALU_SUB;
        PCSrc   = PC_BRANCH;
        PCWrite = Opcode[0] ? ~Zero : Zero;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PC_JUMP;
      end
      HALT: begin
        Halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a directed vector table, hand-written
// halt / reset corner sequences, then randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_control_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
  logic        iord, irwrite, pcwrite, halted;
  logic [1:0]  aluop, pcsrc;
  logic [3:0]  state;
  logic [15:0] instr_count;

  logic        regdst2, alusrc2, memread2, memwrite2, memtoreg2, regwrite2;
  logic        iord2, irwrite2, pcwrite2, halted2;
  logic [1:0]  aluop2, pcsrc2;
  logic [3:0]  state2;
  logic [1:0]  instr_count2;

  multicycle_control_fsm #(.CNT_W(16)) u_dut (
    .Clock(clk), .Reset(rst), .Opcode(opcode), .Zero(zero), .MemReady(mem_ready),
    .RegDst(regdst), .ALUSrc(alusrc), .ALUOp(aluop), .MemRead(memread),
    .MemWrite(memwrite), .MemToReg(memtoreg), .RegWrite(regwrite), .IorD(iord),
    .IRWrite(irwrite), .PCWrite(pcwrite), .PCSrc(pcsrc), .Halted(halted),
    .State(state), .InstrCount(instr_count)
  );

  // Narrow-counter instance to exercise InstrCount wrap-around.
  multicycle_control_fsm #(.CNT_W(2)) u_dut_w2 (
    .Clock(clk), .Reset(rst), .Opcode(opcode), .Zero(zero), .MemReady(mem_ready),
    .RegDst(regdst2), .ALUSrc(alusrc2), .ALUOp(aluop2), .MemRead(memread2),
    .MemWrite(memwrite2), .MemToReg(memtoreg2), .RegWrite(regwrite2), .IorD(iord2),
    .IRWrite(irwrite2), .PCWrite(pcwrite2), .PCSrc(pcsrc2), .Halted(halted2),
    .State(state2), .InstrCount(instr_count2)
  );

  // Control bundle: {RegDst,ALUSrc,ALUOp,MemRead,MemWrite,MemToReg,
  //                  RegWrite,IorD,IRWrite,PCWrite,PCSrc,Halted}
  logic [13:0] ctrl;
  assign ctrl = {regdst, alusrc, aluop, memread, memwrite, memtoreg,
                 regwrite, iord, irwrite, pcwrite, pcsrc, halted};

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_MEM_WR = 4'd6, S_WB_R = 4'd7,    S_WB_I = 4'd8,
                         S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_HALT = 4'd12;

  localparam logic [13:0] C_FETCH_GO   = 14'b0_0_00_1_0_0_0_0_1_1_00_0;
  localparam logic [13:0] C_FETCH_WAIT = 14'b0_0_00_1_0_0_0_0_1_0_00_0;
  localparam logic [13:0] C_DECODE     = 14'b0_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_EXEC_R     = 14'b0_0_10_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_WB_R       = 14'b1_0_10_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] C_EXEC_I     = 14'b0_1_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_WB_I       = 14'b0_1_00_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] C_MEM_ADDR   = 14'b0_1_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_MEM_RD     = 14'b0_0_00_1_0_0_0_1_0_0_00_0;
  localparam logic [13:0] C_MEM_WR     = 14'b0_0_00_0_1_0_0_1_0_0_00_0;
  localparam logic [13:0] C_WB_MEM     = 14'b0_0_00_0_0_1_1_0_0_0_00_0;
  localparam logic [13:0] C_BR_TAKEN   = 14'b0_0_01_0_0_0_0_0_0_1_01_0;
  localparam logic [13:0] C_BR_NOT     = 14'b0_0_01_0_0_0_0_0_0_0_01_0;
  localparam logic [13:0] C_JUMP       = 14'b0_0_00_0_0_0_0_0_0_1_10_0;
  localparam logic [13:0] C_HALT       = 14'b0_0_00_0_0_0_0_0_0_0_00_1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] es,
                           input logic [13:0] ec, input int cnt);
    cmp({tag, " state"}, 32'(state), 32'(es));
    cmp({tag, " ctrl"},  32'(ctrl),  32'(ec));
    cmp({tag, " count"}, 32'(instr_count), 32'(cnt & 16'hffff));
    cmp({tag, " count_w2"}, 32'(instr_count2), 32'(cnt % 4));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic mr, input logic z, input logic [2:0] op);
    rst = r; mem_ready = mr; zero = z; opcode = op;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [2:0]  op;
    logic        chk;
    logic [3:0]  st;
    logic [13:0] c;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic mr, input logic z, input logic [2:0] op,
                     input logic chk, input logic [3:0] st, input logic [13:0] c, input int cnt);
    vec_t v;
    v.rst = r; v.mr = mr; v.z = z; v.op = op; v.chk = chk; v.st = st; v.c = c; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Expected controls for a cycle spent in a given step of an instruction.
  function automatic logic [13:0] model_ctrl(input logic [3:0] st, input logic [2:0] op,
                                             input logic z, input logic mr);
    logic taken;
    taken = (op == 3'b100) ? z : ~z;
    case (st)
      S_FETCH:    return mr ? C_FETCH_GO : C_FETCH_WAIT;
      S_DECODE:   return C_DECODE;
      S_EXEC_R:   return C_EXEC_R;
      S_WB_R:     return C_WB_R;
      S_EXEC_I:   return C_EXEC_I;
      S_WB_I:     return C_WB_I;
      S_MEM_ADDR: return C_MEM_ADDR;
      S_MEM_RD:   return C_MEM_RD;
      S_MEM_WR:   return C_MEM_WR;
      S_WB_MEM:   return C_WB_MEM;
      S_BRANCH:   return taken ? C_BR_TAKEN : C_BR_NOT;
      S_JUMP:     return C_JUMP;
      default:    return C_HALT;
    endcase
  endfunction

  typedef struct {
    logic       rst;
    logic       mr;
    logic [2:0] op;
    logic [3:0] st;
  } cyc_t;

  cyc_t plan[$];

  task automatic plan_push(input logic r, input logic mr, input logic [2:0] op, input logic [3:0] st);
    cyc_t c;
    c.rst = r; c.mr = mr; c.op = op; c.st = st;
    plan.push_back(c);
  endtask

  // Expand one instruction into its expected cycle-by-cycle step list.
  task automatic plan_instr(input logic [2:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) plan_push(1'b0, 1'b0, 3'($urandom_range(0, 7)), S_FETCH);
    plan_push(1'b0, 1'b1, 3'($urandom_range(0, 7)), S_FETCH);
    plan_push(1'b0, 1'($urandom_range(0, 1)), op, S_DECODE);
    case (op)
      3'b000: begin plan_push(0, 1'($urandom), op, S_EXEC_R); plan_push(0, 1'($urandom), op, S_WB_R); end
      3'b001: begin plan_push(0, 1'($urandom), op, S_EXEC_I); plan_push(0, 1'($urandom), op, S_WB_I); end
      3'b010: begin
        plan_push(0, 1'($urandom), op, S_MEM_ADDR);
        for (int i = 0; i < mw; i++) plan_push(0, 1'b0, op, S_MEM_RD);
        plan_push(0, 1'b1, op, S_MEM_RD);
        plan_push(0, 1'($urandom), op, S_WB_MEM);
      end
      3'b011: begin
        plan_push(0, 1'($urandom), op, S_MEM_ADDR);
        for (int i = 0; i < mw; i++) plan_push(0, 1'b0, op, S_MEM_WR);
        plan_push(0, 1'b1, op, S_MEM_WR);
      end
      3'b100, 3'b101: plan_push(0, 1'($urandom), op, S_BRANCH);
      3'b110:         plan_push(0, 1'($urandom), op, S_JUMP);
      default: begin
        plan_push(0, 1'($urandom), op, S_HALT);
        plan_push(0, 1'($urandom), op, S_HALT);
        plan_push(1, 1'($urandom), op, S_HALT);
      end
    endcase
  endtask

  // ---------------- test ----------------
  int exp_cnt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'b000);

    // R-type after a 3-cycle reset, then LW with fetch/memory waits.
    add(1,1,0,3'b000, 0, S_FETCH,    C_FETCH_GO,   0);
    add(1,1,0,3'b000, 0, S_FETCH,    C_FETCH_GO,   0);
    add(1,1,0,3'b000, 1, S_FETCH,    C_FETCH_GO,   0);
    add(0,1,0,3'b000, 1, S_FETCH,    C_FETCH_GO,   0);
    add(0,1,0,3'b000, 1, S_DECODE,   C_DECODE,     1);
    add(0,1,0,3'b000, 1, S_EXEC_R,   C_EXEC_R,     1);
    add(0,1,0,3'b000, 1, S_WB_R,     C_WB_R,       1);
    add(0,0,0,3'b010, 1, S_FETCH,    C_FETCH_WAIT, 1);
    add(0,0,0,3'b010, 1, S_FETCH,    C_FETCH_WAIT, 1);
    add(0,1,0,3'b010, 1, S_FETCH,    C_FETCH_GO,   1);
    add(0,1,0,3'b010, 1, S_DECODE,   C_DECODE,     2);
    add(0,1,0,3'b010, 1, S_MEM_ADDR, C_MEM_ADDR,   2);
    add(0,0,0,3'b010, 1, S_MEM_RD,   C_MEM_RD,     2);
    add(0,0,0,3'b010, 1, S_MEM_RD,   C_MEM_RD,     2);
    add(0,0,0,3'b010, 1, S_MEM_RD,   C_MEM_RD,     2);
    add(0,1,0,3'b010, 1, S_MEM_RD,   C_MEM_RD,     2);
    add(0,1,0,3'b010, 1, S_WB_MEM,   C_WB_MEM,     2);
    // BEQ / BNE with both Zero values.
    add(0,1,0,3'b100, 1, S_FETCH,    C_FETCH_GO,   2);
    add(0,1,0,3'b100, 1, S_DECODE,   C_DECODE,     3);
    add(0,1,1,3'b100, 1, S_BRANCH,   C_BR_TAKEN,   3);
    add(0,1,0,3'b100, 1, S_FETCH,    C_FETCH_GO,   3);
    add(0,1,0,3'b100, 1, S_DECODE,   C_DECODE,     4);
    add(0,1,0,3'b100, 1, S_BRANCH,   C_BR_NOT,     4);
    add(0,1,0,3'b101, 1, S_FETCH,    C_FETCH_GO,   4);
    add(0,1,0,3'b101, 1, S_DECODE,   C_DECODE,     5);
    add(0,1,1,3'b101, 1, S_BRANCH,   C_BR_NOT,     5);
    add(0,1,0,3'b101, 1, S_FETCH,    C_FETCH_GO,   5);
    add(0,1,0,3'b101, 1, S_DECODE,   C_DECODE,     6);
    add(0,1,0,3'b101, 1, S_BRANCH,   C_BR_TAKEN,   6);
    // SW then JMP back-to-back.
    add(0,1,0,3'b011, 1, S_FETCH,    C_FETCH_GO,   6);
    add(0,1,0,3'b011, 1, S_DECODE,   C_DECODE,     7);
    add(0,1,0,3'b011, 1, S_MEM_ADDR, C_MEM_ADDR,   7);
    add(0,1,0,3'b011, 1, S_MEM_WR,   C_MEM_WR,     7);
    add(0,1,0,3'b110, 1, S_FETCH,    C_FETCH_GO,   7);
    add(0,1,0,3'b110, 1, S_DECODE,   C_DECODE,     8);
    add(0,1,0,3'b110, 1, S_JUMP,     C_JUMP,       8);
    // HALT entry.
    add(0,1,0,3'b111, 1, S_FETCH,    C_FETCH_GO,   8);
    add(0,1,0,3'b111, 1, S_DECODE,   C_DECODE,     9);

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mr, tbl[i].z, tbl[i].op);
      @(negedge clk);
      if (tbl[i].chk) check_all($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].c, tbl[i].cnt);
      next_cycle();
    end

    // HALT holds for 20 cycles regardless of MemReady / Opcode / Zero.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
      @(negedge clk);
      check_all($sformatf("halt_hold[%0d]", i), S_HALT, C_HALT, 9);
      next_cycle();
    end
    // Reset leaves HALT; counter clears.
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    check_all("halt_reset_cycle", S_HALT, C_HALT, 9);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b010);
    @(negedge clk);
    check_all("after_halt_reset", S_FETCH, C_FETCH_WAIT, 0);
    next_cycle();

    // Reset asserted during a MEM_RD wait.
    drive(1'b0, 1'b1, 1'b0, 3'b010); @(negedge clk); check_all("rw_fetch",  S_FETCH,    C_FETCH_GO, 0); next_cycle();
    drive(1'b0, 1'b1, 1'b0, 3'b010); @(negedge clk); check_all("rw_decode", S_DECODE,   C_DECODE,   1); next_cycle();
    drive(1'b0, 1'b1, 1'b0, 3'b010); @(negedge clk); check_all("rw_addr",   S_MEM_ADDR, C_MEM_ADDR, 1); next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b010); @(negedge clk); check_all("rw_wait",   S_MEM_RD,   C_MEM_RD,   1); next_cycle();
    drive(1'b1, 1'b0, 1'b0, 3'b010); @(negedge clk); check_all("rw_wait_r", S_MEM_RD,   C_MEM_RD,   1); next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b010); @(negedge clk); check_all("rw_after",  S_FETCH,    C_FETCH_WAIT, 0); next_cycle();

    // Randomized instruction streams against the reference model.
    exp_cnt = 0;
    for (int n = 0; n < 250; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 6));
      plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      foreach (plan[k]) begin
        logic z;
        z = 1'($urandom);
        drive(plan[k].rst, plan[k].mr, z, plan[k].op);
        @(negedge clk);
        check_all($sformatf("rnd[%0d.%0d]", n, k), plan[k].st,
                  model_ctrl(plan[k].st, plan[k].op, z, plan[k].mr), exp_cnt);
        if (plan[k].rst) exp_cnt = 0;
        else if (plan[k].st == S_FETCH && plan[k].mr) exp_cnt = exp_cnt + 1;
        next_cycle();
      end
      plan.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 16-bit datapath. Replaces the single-cycle decode with a Moore FSM that steps each instruction through fetch/decode/execute/memory/writeback.
- Fetch and data accesses share one memory port. The block drives the memory handshake and holds all controls stable across wait states.
- Sits beside the Datapath. Consumes the 3-bit Opcode from the instruction register and the ALU Zero flag.

Parameters:
- CNT_W, 16, width of the retired-instruction counter InstrCount.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  3  opcode field from the instruction register.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access completes this cycle.
- RegDst  output  1  write register taken from the rd field.
- ALUSrc  output  1  ALU B operand is the sign-extended immediate.
- ALUOp  output  2  00 add, 01 sub, 10 use funct field.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemToReg  output  1  writeback data comes from the memory data register.
- RegWrite  output  1  register file write enable.
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  instruction register load.
- PCWrite  output  1  PC load.
- PCSrc  output  2  00 PC+2, 01 branch target (ALUOut), 10 jump target.
- Halted  output  1  FSM is in HALT.
- State  output  4  current state encoding, for debug.
- InstrCount  output  CNT_W  number of fetched instructions.

Behaviour:
- Opcode map: 000 R-type, 001 ADDI, 010 LW, 011 SW, 100 BEQ, 101 BNE, 110 JMP, 111 HALT.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, HALT=12. Codes 13-15 go to FETCH on the next edge.
- Reset: when Reset=1 at an edge, state=FETCH and InstrCount=0.
  - Reset wins over every other event, including mid-wait states.
  - Outputs decode from the registered state, so the first cycle after reset shows FETCH outputs.
- All outputs are 0 unless listed for a state. PCSrc=00 unless listed.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrc=0, ALUOp=00.
  - PCWrite=MemReady, PCSrc=00.
  - If MemReady=1: go to DECODE and InstrCount+1 (wraps at 2^CNT_W).
  - If MemReady=0: stay, with all outputs held stable.
- DECODE: ALUOp=00 (branch-target compute). Next state by Opcode:
  - 000 -> EXEC_R; 001 -> EXEC_I; 010/011 -> MEM_ADDR.
  - 100/101 -> BRANCH; 110 -> JUMP; 111 -> HALT.
- EXEC_R: ALUOp=10 -> WB_R.
- WB_R: RegDst=1, RegWrite=1, ALUOp=10 -> FETCH.
- EXEC_I: ALUSrc=1, ALUOp=00 -> WB_I.
- WB_I: RegWrite=1, ALUSrc=1 -> FETCH.
- MEM_ADDR: ALUSrc=1, ALUOp=00. Opcode 010 -> MEM_RD; 011 -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. MemReady=1 -> WB_MEM; else stay.
- MEM_WR: MemWrite=1, IorD=1. MemReady=1 -> FETCH; else stay.
- WB_MEM: RegWrite=1, MemToReg=1 -> FETCH.
- BRANCH: ALUOp=01, PCSrc=01 -> FETCH.
  - PCWrite = Zero for Opcode 100, ~Zero for Opcode 101.
- JUMP: PCWrite=1, PCSrc=10 -> FETCH.
- HALT: Halted=1, all other outputs 0. Stays until Reset.
- Opcode is sampled every cycle and is valid only while IR is stable, i.e. in any state after FETCH completes.
- MemReady is ignored outside FETCH, MEM_RD and MEM_WR.
- Zero-wait latencies (MemReady=1 throughout), in cycles:
  - R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, JMP 3.
- Each memory wait cycle adds exactly one cycle.
- MemRead and MemWrite are never 1 in the same cycle.
- RegWrite and PCWrite are never 1 in the same cycle.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 and Opcode=000 -> State sequence 0,1,2,7,0. RegWrite=1 and RegDst=1 only in the WB_R cycle. InstrCount=1 after FETCH.
- LW with MemReady low for 2 cycles in FETCH and 3 cycles in MEM_RD -> total 10 cycles. MemRead, IorD and PCWrite=0 held stable through the waits. PCWrite pulses once, on the FETCH completion cycle.
- BEQ with Zero=1 -> PCWrite=1 and PCSrc=01 in the BRANCH cycle. BEQ with Zero=0 -> PCWrite=0. BNE gives the inverse for both cases.
- SW then JMP back-to-back -> MemWrite=1 and IorD=1 in MEM_WR. JUMP cycle shows PCWrite=1, PCSrc=10. InstrCount increments by 2.
- Opcode=111 -> Halted=1 from the cycle after DECODE. Holds for 20 cycles regardless of MemReady/Opcode. Reset returns State to 0 and InstrCount to 0.
- Reset asserted during a MEM_RD wait -> next cycle State=0, MemRead=1, IorD=0, InstrCount=0. CNT_W=2 with 5 fetches -> InstrCount wraps to 1.
